// File: rtl/dma_read_fifo.sv
// rtl/dma_read_fifo.sv - elastic read-data FIFO with conservative free count and FWFT output
module dma_read_fifo #(
    parameter int DataBits     = 64,
    parameter int DepthBits    = 9,
    parameter int FifoUsedBits = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [DataBits-1:0]     din_data,
    input  logic                    din_eof,
    output logic [FifoUsedBits-1:0] din_free,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [DataBits-1:0]     dout_data,
    output logic                    dout_eof,
    output logic [FifoUsedBits-1:0] count
);

    localparam int Depth = 2 ** DepthBits;
    localparam logic [FifoUsedBits-1:0] DepthCnt = FifoUsedBits'(Depth);
    localparam logic [FifoUsedBits-1:0] OneCnt   = FifoUsedBits'(1);

    logic [DataBits:0]          mem [Depth];
    logic [DepthBits-1:0]       wr_ptr;
    logic [DepthBits-1:0]       rd_ptr;
    logic [FifoUsedBits-1:0]    ram_words;
    logic [DataBits:0]          ram_q;
    logic                       ram_q_valid;
    logic                       push;
    logic                       pop;
    logic                       rd_en;
    logic                       load_out;
    logic [FifoUsedBits-1:0]    count_next;
    logic [FifoUsedBits-1:0]    ram_words_next;

    assign push     = din_valid & din_ready;
    assign pop      = dout_valid & dout_ready;
    // ram_q acts as a skid stage: it only advances when the output register can take it
    assign load_out = ram_q_valid & (~dout_valid | dout_ready);
    assign rd_en    = (ram_words != '0) & (~ram_q_valid | load_out);

    always_comb begin
        count_next     = count;
        ram_words_next = ram_words;
        if (push && !pop) begin
            count_next = count + OneCnt;
        end else if (pop && !push) begin
            count_next = count - OneCnt;
        end
        if (push && !rd_en) begin
            ram_words_next = ram_words + OneCnt;
        end else if (rd_en && !push) begin
            ram_words_next = ram_words - OneCnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_words   <= '0;
            ram_q_valid <= 1'b0;
            dout_valid  <= 1'b0;
            count       <= '0;
            din_free    <= DepthCnt;
            din_ready   <= 1'b1;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_words   <= '0;
            ram_q_valid <= 1'b0;
            dout_valid  <= 1'b0;
            count       <= '0;
            din_free    <= DepthCnt;
            din_ready   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DepthBits'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + DepthBits'(1);
            end
            ram_words <= ram_words_next;
            if (rd_en) begin
                ram_q_valid <= 1'b1;
            end else if (load_out) begin
                ram_q_valid <= 1'b0;
            end
            if (load_out) begin
                dout_valid <= 1'b1;
            end else if (pop) begin
                dout_valid <= 1'b0;
            end
            count     <= count_next;
            din_free  <= DepthCnt - count_next;
            din_ready <= (count_next < DepthCnt);
        end
    end

    // Data path carries no reset; its contents are qualified by the valid flags above
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {din_eof, din_data};
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr];
        end
        if (load_out) begin
            {dout_eof, dout_data} <= ram_q;
        end
    end

endmodule

// File: tb/tb_dma_read_fifo.sv
// tb/tb_dma_read_fifo.sv - directed self-checking bench for dma_read_fifo
module tb_dma_read_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] din_data;
    logic        din_eof;
    logic [9:0]  din_free;
    logic        dout_valid;
    logic        dout_ready;
    logic [63:0] dout_data;
    logic        dout_eof;
    logic [9:0]  count;

    int vectors = 0;
    int miscompares = 0;

    dma_read_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .din_eof    (din_eof),
        .din_free   (din_free),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_eof   (dout_eof),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; din_valid = 1'b1; din_data = 64'h1; din_eof = 1'b0; dout_ready = 1'b0;
        repeat (3) step();
        vectors++;
        if ({din_ready, dout_valid, count, din_free} !== {1'b1, 1'b0, 10'd0, 10'd512}) begin
            $display("FAIL reset_hold: rdy=%b vld=%b count=%0d free=%0d, need 1 0 0 512", din_ready, dout_valid, count, din_free);
            miscompares++;
        end
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if ({din_ready, dout_valid, count, din_free} !== {1'b1, 1'b0, 10'd0, 10'd512}) begin
            $display("FAIL reset_release: rdy=%b vld=%b count=%0d free=%0d, need 1 0 0 512", din_ready, dout_valid, count, din_free);
            miscompares++;
        end
    endtask

    task automatic test_single_word();
        din_valid = 1'b1; din_data = 64'hA5; din_eof = 1'b1;
        step();
        din_valid = 1'b0; din_eof = 1'b0;
        vectors++;
        if ({dout_valid, count, din_free} !== {1'b0, 10'd1, 10'd511}) begin
            $display("FAIL single_edge_k: vld=%b count=%0d free=%0d, need 0 1 511", dout_valid, count, din_free);
            miscompares++;
        end
        step();
        vectors++;
        if (dout_valid !== 1'b0) begin
            $display("FAIL single_edge_k1: vld=%b, need 0", dout_valid);
            miscompares++;
        end
        step();
        vectors++;
        if ({dout_valid, dout_eof, dout_data} !== {1'b1, 1'b1, 64'hA5}) begin
            $display("FAIL single_edge_k2: vld=%b eof=%b data=%h, need 1 1 a5", dout_valid, dout_eof, dout_data);
            miscompares++;
        end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        vectors++;
        if ({dout_valid, count, din_free} !== {1'b0, 10'd0, 10'd512}) begin
            $display("FAIL single_pop: vld=%b count=%0d free=%0d, need 0 0 512", dout_valid, count, din_free);
            miscompares++;
        end
    endtask

    task automatic test_fill_and_full_pop();
        int err;
        err = 0;
        dout_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            din_valid = 1'b1; din_data = 64'(i); din_eof = (i == 511);
            if (din_ready !== 1'b1 && err == 0) begin
                $display("FAIL fill_ready: word %0d saw din_ready=%b, need 1", i, din_ready);
                err = 1;
            end
            step();
        end
        vectors++;
        if (err != 0) miscompares++;
        din_valid = 1'b1; din_data = 64'hDEAD; din_eof = 1'b0;
        vectors++;
        if ({din_ready, din_free, count} !== {1'b0, 10'd0, 10'd512}) begin
            $display("FAIL fill_full: rdy=%b free=%0d count=%0d, need 0 0 512", din_ready, din_free, count);
            miscompares++;
        end
        vectors++;
        if ({dout_valid, dout_data} !== {1'b1, 64'd0}) begin
            $display("FAIL full_head: vld=%b data=%h, need 1 0", dout_valid, dout_data);
            miscompares++;
        end
        dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        vectors++;
        if ({count, din_ready, din_free} !== {10'd511, 1'b1, 10'd1}) begin
            $display("FAIL full_push_pop: count=%0d rdy=%b free=%0d, need 511 1 1", count, din_ready, din_free);
            miscompares++;
        end
        err = 0;
        for (int i = 1; i < 512; i++) begin
            if ((dout_valid !== 1'b1 || dout_data !== 64'(i) || dout_eof !== (i == 511)) && err == 0) begin
                $display("FAIL drain_order: vld=%b data=%0d eof=%b, need 1 %0d %b", dout_valid, dout_data, dout_eof, i, (i == 511));
                err = 1;
            end
            step();
        end
        vectors++;
        if (err != 0) miscompares++;
        dout_ready = 1'b0;
        vectors++;
        if ({dout_valid, count, din_free} !== {1'b0, 10'd0, 10'd512}) begin
            $display("FAIL drain_empty: vld=%b count=%0d free=%0d, need 0 0 512 (blocked word must not appear)", dout_valid, count, din_free);
            miscompares++;
        end
    endtask

    task automatic test_streaming();
        int pushed, popped, first_seen, err_order, err_gap, err_free, err_rdy;
        logic was_valid;
        pushed = 0; popped = 0; first_seen = -1;
        err_order = 0; err_gap = 0; err_free = 0; err_rdy = 0;
        dout_ready = 1'b1;
        for (int cyc = 0; cyc < 1100 && popped < 1000; cyc++) begin
            din_valid = (pushed < 1000);
            din_data  = 64'(1000 + pushed);
            din_eof   = (pushed % 7 == 0);
            if (din_valid && din_ready !== 1'b1 && err_rdy == 0) begin
                $display("FAIL stream_ready: cycle %0d din_ready=%b, need 1", cyc, din_ready);
                err_rdy = 1;
            end
            was_valid = dout_valid;
            if (was_valid && (dout_data !== 64'(1000 + popped) || dout_eof !== (popped % 7 == 0)) && err_order == 0) begin
                $display("FAIL stream_order: data=%0d eof=%b, need %0d %b", dout_data, dout_eof, 1000 + popped, (popped % 7 == 0));
                err_order = 1;
            end
            step();
            if (din_valid) pushed++;
            if (was_valid === 1'b1) popped++;
            if (first_seen < 0 && dout_valid === 1'b1) first_seen = cyc;
            if (first_seen >= 0 && popped < 1000 && dout_valid !== 1'b1 && err_gap == 0) begin
                $display("FAIL stream_gap: cycle %0d dout_valid=%b after %0d pops, need 1", cyc, dout_valid, popped);
                err_gap = 1;
            end
            if ((count !== 10'(pushed - popped) || din_free !== 10'(512 - (pushed - popped))) && err_free == 0) begin
                $display("FAIL stream_count: count=%0d free=%0d, need %0d %0d", count, din_free, pushed - popped, 512 - (pushed - popped));
                err_free = 1;
            end
        end
        din_valid = 1'b0;
        dout_ready = 1'b0;
        vectors += 4;
        miscompares += err_rdy + err_order + err_gap + err_free;
        vectors++;
        if (first_seen != 2) begin
            $display("FAIL stream_latency: first word after edge %0d, need 2", first_seen);
            miscompares++;
        end
        vectors++;
        if (popped != 1000 || count !== 10'd0) begin
            $display("FAIL stream_total: popped=%0d count=%0d, need 1000 0", popped, count);
            miscompares++;
        end
    endtask

    task automatic test_flush();
        dout_ready = 1'b0;
        for (int i = 0; i < 37; i++) begin
            din_valid = 1'b1; din_data = 64'(i); din_eof = 1'b0;
            step();
        end
        vectors++;
        if (count !== 10'd37) begin
            $display("FAIL flush_pre: count=%0d, need 37", count);
            miscompares++;
        end
        din_data = 64'h55; flush = 1'b1; dout_ready = 1'b1;
        step();
        flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        vectors++;
        if ({count, dout_valid, din_free, din_ready} !== {10'd0, 1'b0, 10'd512, 1'b1}) begin
            $display("FAIL flush_clear: count=%0d vld=%b free=%0d rdy=%b, need 0 0 512 1", count, dout_valid, din_free, din_ready);
            miscompares++;
        end
        din_valid = 1'b1; din_data = 64'h77; din_eof = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        vectors++;
        if ({dout_valid, dout_eof, dout_data, count} !== {1'b1, 1'b1, 64'h77, 10'd1}) begin
            $display("FAIL flush_after: vld=%b eof=%b data=%h count=%0d, need 1 1 77 1", dout_valid, dout_eof, dout_data, count);
            miscompares++;
        end
    endtask

    task automatic test_reset_midburst();
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1; din_data = 64'(i + 200); din_eof = 1'b0;
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({dout_valid, count, din_free, din_ready} !== {1'b0, 10'd0, 10'd512, 1'b1}) begin
            $display("FAIL async_reset: vld=%b count=%0d free=%0d rdy=%b, need 0 0 512 1", dout_valid, count, din_free, din_ready);
            miscompares++;
        end
        step();
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if ({dout_valid, count} !== {1'b0, 10'd0}) begin
            $display("FAIL reset_no_accept: vld=%b count=%0d, need 0 0", dout_valid, count);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_and_full_pop();
        test_streaming();
        test_flush();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
